seqcon_p: RTL and testbench
===========================

Name: seqcon_p

Overview:
- Parametrised next-generation sequence controller for the RISC-V teaching processor.
- Generates per-cycle datapath strobes: IR, A, B, PDR, port, PC, ALU, RAM, RDR.
- Generalises the fixed 4-phase controller in four ways:
  - configurable opcode width;
  - configurable RAM wait states plus a RDY handshake;
  - a working HOLD stall;
  - a HALT state with restart and single-step.
- Sits between instruction register / status flags and the datapath. Instantiated once in the CPU top.

Parameters:
- OPW, 4, opcode width in bits (≥4). Only codes 0–11 are defined; all others decode as NOP.
- AW, 7, width of the ADDR field passed through for debug/status.
- MEM_WAIT, 0, minimum extra cycles per RAM access (0–15). The access also needs RDY.
- STEP_EN, 1, 1 = STEP input honoured; 0 = STEP ignored.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous active-low reset.
- HOLD  in  1  1 = freeze state, counters and outputs at their current values.
- STEP  in  1  pulse: run exactly one instruction out of HALT.
- START  in  1  pulse: leave HALT and run freely.
- RDY  in  1  RAM ready; an access completes only when RDY=1 and the wait counter is done.
- OPCODE  in  OPW  instruction opcode from IR.
- ADDR  in  AW  operand address (status only).
- CF, OF, SF, ZF  in  1 each  ALU flags.
- I  in  1  immediate-mode bit.
- IR_EN, A_EN, B_EN, PDR_EN, PORT_EN, PORT_RD, PC_EN, PC_LOAD, ALU_EN, ALU_OE, RAM_OE, RDR_EN, RAM_CS  out  1 each  datapath strobes, active high.
- PHASE  out  3  encoded current state.
- HALTED  out  1  1 while in HALT.

Behaviour:
- State encoding: FETCH=0, FWAIT=1, DECODE=2, EXEC=3, MWAIT=4, WB=5, HALT=6.
- Outputs are decoded from the registered state plus the latched opcode/flags; no extra latency.
- Reset (RST=0 at a CLK edge):
  - state→FETCH, wait counter→0, single-step flag→0;
  - all strobes 0, HALTED=0.
  - Reset mid-instruction aborts that instruction; no partial strobes follow.
  - Reset dominates HOLD, STEP and START.
- HOLD=1: no state, counter or latch updates; strobes stay asserted as in the held state. Reset still acts.
- FETCH: RAM_CS=1, RAM_OE=1; wait counter loads MEM_WAIT; next state is FWAIT.
- FWAIT:
  - RAM_CS and RAM_OE stay 1; counter decrements toward 0.
  - When counter=0 and RDY=1: IR_EN=1, RDR_EN=1, next state DECODE. Otherwise stay.
  - With MEM_WAIT=0 and RDY=1, a fetch is exactly 2 cycles.
- DECODE:
  - PC_EN=1 (PC increment).
  - Latch OPCODE, I, CF, OF, SF, ZF into internal registers.
  - Next state EXEC, except opcode 0 (HLT) → HALT.
- EXEC, per latched opcode:
  - 1 LDA, I=1: A_EN=1 (operand from IR), next WB. I=0: RAM_CS=1, RAM_OE=1, load counter, next MWAIT.
  - 11 LDB: same as LDA, but targets B.
  - 2 STA: RAM_CS=1, ALU_OE=1, load counter, next MWAIT (write access, RAM_OE=0).
  - 3 ALU: ALU_EN=1, next WB.
  - 4 JMP: PC_LOAD=1, next WB.
  - 5 JZ, 6 JC, 7 JN, 8 JV: PC_LOAD=1 only if the latched ZF/CF/SF/OF=1; next WB.
  - 9 IN: PORT_RD=1, PDR_EN=1, next WB.
  - 10 OUT: PORT_EN=1, next WB.
  - Others: NOP, next WB.
- MWAIT:
  - Strobes stay as in EXEC for that opcode.
  - Complete when counter=0 and RDY=1: LDA/LDB assert RDR_EN=1 and A_EN/B_EN=1; STA asserts nothing extra. Next WB.
- WB:
  - ALU opcode: ALU_OE=1, A_EN=1. All other opcodes: no strobes.
  - Next FETCH, or HALT if the single-step flag is set (flag then clears).
- HALT:
  - HALTED=1, all strobes 0.
  - START → FETCH.
  - STEP (STEP_EN=1) → set single-step flag, go to FETCH.
  - START and STEP together: START wins, flag stays clear.
- Flag semantics: jumps use flags latched at DECODE; flag changes during EXEC are ignored.
- Wait counter is 4 bits and never underflows: it saturates at 0 while RDY=0.

Decomposition:
- Package seqcon_pkg:
  - state enum (state_t);
  - opcode constants OP_HLT … OP_LDB;
  - control-word struct of the 13 strobes, so the decoder returns one struct.
- One natural sub-module: seqcon_wait, the wait-state counter with load/decrement/done and RDY qualification.

Test Plan:
- Reset: RST=0 for 2 cycles mid-EXEC of an ALU op → next cycle PHASE=0 and all strobes 0; first FETCH follows with RAM_CS=1.
- ALU op, MEM_WAIT=0, RDY=1 → exactly 5 cycles FETCH→FWAIT→DECODE→EXEC→WB. IR_EN in cycle 2, ALU_EN in cycle 4, ALU_OE+A_EN in cycle 5.
- LDA with I=0, MEM_WAIT=2, RDY low for 3 extra cycles during MWAIT → RDR_EN+A_EN assert exactly once, on the first cycle with counter=0 and RDY=1.
- JZ with ZF=1 latched at DECODE, ZF forced to 0 during EXEC → PC_LOAD=1. Repeat with ZF=0 latched → PC_LOAD stays 0.
- HLT → HALTED=1 within 3 cycles. STEP pulse → one instruction completes, then HALTED=1 again. START → free run resumes.
- HOLD=1 for 4 cycles during FWAIT → PHASE and strobes unchanged. Fetch resumes and completes normally after release.

Source files
------------

// File: rtl/seqcon_pkg.sv
// seqcon_pkg: shared types and constants for the seqcon_p sequence controller.
//   state_t  - controller state; the encoding is visible on PHASE.
//   OP_*     - defined opcode values; any other code executes as a NOP.
//   ctrl_t   - the 13 datapath strobes, returned as one word by the decoder.
//   WAIT_W   - width of the RAM wait-state counter.
package seqcon_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_FWAIT  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MWAIT  = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    localparam int OP_HLT = 0;
    localparam int OP_LDA = 1;
    localparam int OP_STA = 2;
    localparam int OP_ALU = 3;
    localparam int OP_JMP = 4;
    localparam int OP_JZ  = 5;
    localparam int OP_JC  = 6;
    localparam int OP_JN  = 7;
    localparam int OP_JV  = 8;
    localparam int OP_IN  = 9;
    localparam int OP_OUT = 10;
    localparam int OP_LDB = 11;

    localparam int WAIT_W = 4;

    typedef struct packed {
        logic ir_en;
        logic a_en;
        logic b_en;
        logic pdr_en;
        logic port_en;
        logic port_rd;
        logic pc_en;
        logic pc_load;
        logic alu_en;
        logic alu_oe;
        logic ram_oe;
        logic rdr_en;
        logic ram_cs;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/seqcon_wait.sv
// seqcon_wait: RAM wait-state counter.
//   CLK, RST     - clock, synchronous active-low reset (count -> 0)
//   i_hold       - freeze the count
//   i_load       - load i_load_val (takes priority over decrement)
//   i_dec        - count down one step, saturating at zero
//   i_rdy        - RAM ready from the memory
//   o_done       - access may complete: count is zero and RAM is ready
module seqcon_wait
    import seqcon_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_hold,
    input  logic              i_load,
    input  logic [WAIT_W-1:0] i_load_val,
    input  logic              i_dec,
    input  logic              i_rdy,
    output logic              o_done
);

    logic [WAIT_W-1:0] r_count;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_count <= '0;
        end else if (!i_hold) begin
            if (i_load) begin
                r_count <= i_load_val;
            end else if (i_dec && (r_count != '0)) begin
                // Parks at zero while waiting on RDY instead of wrapping.
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_done = (r_count == '0) && i_rdy;

endmodule

// File: rtl/seqcon_p.sv
// seqcon_p: parametrised sequence controller for the teaching CPU.
// Walks FETCH -> FWAIT -> DECODE -> EXEC [-> MWAIT] -> WB per instruction and
// decodes the datapath strobes from the registered state plus the opcode and
// flags captured in DECODE. Supports RAM wait states with RDY, a HOLD stall,
// and a HALT state left by START (free run) or STEP (one instruction).
//   CLK, RST          - clock, synchronous active-low reset
//   HOLD, STEP, START - stall / single-step / run controls
//   RDY               - RAM ready
//   OPCODE, ADDR, I   - instruction fields from IR (ADDR is status only)
//   CF, OF, SF, ZF    - ALU flags
//   IR_EN .. RAM_CS   - active-high datapath strobes
//   PHASE, HALTED     - current state encoding, halt indication
module seqcon_p
    import seqcon_pkg::*;
#(
    parameter int OPW      = 4,
    parameter int AW       = 7,
    parameter int MEM_WAIT = 0,
    parameter int STEP_EN  = 1
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           HOLD,
    input  logic           STEP,
    input  logic           START,
    input  logic           RDY,
    input  logic [OPW-1:0] OPCODE,
    input  logic [AW-1:0]  ADDR,
    input  logic           CF,
    input  logic           OF,
    input  logic           SF,
    input  logic           ZF,
    input  logic           I,
    output logic           IR_EN,
    output logic           A_EN,
    output logic           B_EN,
    output logic           PDR_EN,
    output logic           PORT_EN,
    output logic           PORT_RD,
    output logic           PC_EN,
    output logic           PC_LOAD,
    output logic           ALU_EN,
    output logic           ALU_OE,
    output logic           RAM_OE,
    output logic           RDR_EN,
    output logic           RAM_CS,
    output logic [2:0]     PHASE,
    output logic           HALTED
);

    localparam logic [WAIT_W-1:0] LOAD_VAL = WAIT_W'(MEM_WAIT);

    state_t         r_state, w_state_next;
    logic           r_step, w_step_next;
    logic [OPW-1:0] r_opcode;
    logic           r_i, r_cf, r_of, r_sf, r_zf;

    logic  w_load, w_dec, w_done;
    logic  w_op_lda, w_op_ldb, w_op_sta, w_op_alu;
    ctrl_t w_ctrl, w_out;

    // ADDR is carried for status only; nothing here consumes it.
    logic w_unused;
    assign w_unused = ^ADDR;

    seqcon_wait u_wait (
        .CLK        (CLK),
        .RST        (RST),
        .i_hold     (HOLD),
        .i_load     (w_load),
        .i_load_val (LOAD_VAL),
        .i_dec      (w_dec),
        .i_rdy      (RDY),
        .o_done     (w_done)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state  <= ST_FETCH;
            r_step   <= 1'b0;
            r_opcode <= '0;
            r_i      <= 1'b0;
            r_cf     <= 1'b0;
            r_of     <= 1'b0;
            r_sf     <= 1'b0;
            r_zf     <= 1'b0;
        end else if (!HOLD) begin
            r_state <= w_state_next;
            r_step  <= w_step_next;
            // Jumps test these snapshots, so flag changes during EXEC are ignored.
            if (r_state == ST_DECODE) begin
                r_opcode <= OPCODE;
                r_i      <= I;
                r_cf     <= CF;
                r_of     <= OF;
                r_sf     <= SF;
                r_zf     <= ZF;
            end
        end
    end

    assign w_op_lda = (r_opcode == OPW'(OP_LDA));
    assign w_op_ldb = (r_opcode == OPW'(OP_LDB));
    assign w_op_sta = (r_opcode == OPW'(OP_STA));
    assign w_op_alu = (r_opcode == OPW'(OP_ALU));

    always_comb begin
        w_state_next = r_state;
        w_step_next  = r_step;
        w_load       = 1'b0;
        w_dec        = 1'b0;
        w_ctrl       = CTRL_NONE;
        case (r_state)
            ST_FETCH: begin
                w_ctrl.ram_cs = 1'b1;
                w_ctrl.ram_oe = 1'b1;
                w_load        = 1'b1;
                w_state_next  = ST_FWAIT;
            end
            ST_FWAIT: begin
                w_ctrl.ram_cs = 1'b1;
                w_ctrl.ram_oe = 1'b1;
                w_dec         = 1'b1;
                if (w_done) begin
                    w_ctrl.ir_en  = 1'b1;
                    w_ctrl.rdr_en = 1'b1;
                    w_state_next  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                w_ctrl.pc_en = 1'b1;
                // Decided on the live OPCODE, which is being latched this cycle.
                if (OPCODE == OPW'(OP_HLT)) begin
                    w_state_next = ST_HALT;
                    w_step_next  = 1'b0;
                end else begin
                    w_state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_next = ST_WB;
                case (r_opcode)
                    OPW'(OP_LDA), OPW'(OP_LDB): begin
                        if (r_i) begin
                            w_ctrl.a_en = w_op_lda;
                            w_ctrl.b_en = w_op_ldb;
                        end else begin
                            w_ctrl.ram_cs = 1'b1;
                            w_ctrl.ram_oe = 1'b1;
                            w_load        = 1'b1;
                            w_state_next  = ST_MWAIT;
                        end
                    end
                    OPW'(OP_STA): begin
                        w_ctrl.ram_cs = 1'b1;
                        w_ctrl.alu_oe = 1'b1;
                        w_load        = 1'b1;
                        w_state_next  = ST_MWAIT;
                    end
                    OPW'(OP_ALU): w_ctrl.alu_en  = 1'b1;
                    OPW'(OP_JMP): w_ctrl.pc_load = 1'b1;
                    OPW'(OP_JZ):  w_ctrl.pc_load = r_zf;
                    OPW'(OP_JC):  w_ctrl.pc_load = r_cf;
                    OPW'(OP_JN):  w_ctrl.pc_load = r_sf;
                    OPW'(OP_JV):  w_ctrl.pc_load = r_of;
                    OPW'(OP_IN): begin
                        w_ctrl.port_rd = 1'b1;
                        w_ctrl.pdr_en  = 1'b1;
                    end
                    OPW'(OP_OUT): w_ctrl.port_en = 1'b1;
                    default: ;
                endcase
            end
            ST_MWAIT: begin
                // Only LDA/LDB (I=0) and STA reach MWAIT.
                w_dec         = 1'b1;
                w_ctrl.ram_cs = 1'b1;
                w_ctrl.ram_oe = !w_op_sta;
                w_ctrl.alu_oe = w_op_sta;
                if (w_done) begin
                    w_ctrl.rdr_en = !w_op_sta;
                    w_ctrl.a_en   = w_op_lda;
                    w_ctrl.b_en   = w_op_ldb;
                    w_state_next  = ST_WB;
                end
            end
            ST_WB: begin
                w_ctrl.alu_oe = w_op_alu;
                w_ctrl.a_en   = w_op_alu;
                w_state_next  = r_step ? ST_HALT : ST_FETCH;
                w_step_next   = 1'b0;
            end
            ST_HALT: begin
                if (START) begin
                    w_state_next = ST_FETCH;
                    w_step_next  = 1'b0;
                end else if ((STEP_EN != 0) && STEP) begin
                    w_state_next = ST_FETCH;
                    w_step_next  = 1'b1;
                end
            end
            default: w_state_next = ST_FETCH;
        endcase
    end

    // While RST is held low the strobes are forced off, so the reset FETCH
    // state does not drive RAM_CS until reset is released.
    assign w_out   = RST ? w_ctrl : CTRL_NONE;
    assign IR_EN   = w_out.ir_en;
    assign A_EN    = w_out.a_en;
    assign B_EN    = w_out.b_en;
    assign PDR_EN  = w_out.pdr_en;
    assign PORT_EN = w_out.port_en;
    assign PORT_RD = w_out.port_rd;
    assign PC_EN   = w_out.pc_en;
    assign PC_LOAD = w_out.pc_load;
    assign ALU_EN  = w_out.alu_en;
    assign ALU_OE  = w_out.alu_oe;
    assign RAM_OE  = w_out.ram_oe;
    assign RDR_EN  = w_out.rdr_en;
    assign RAM_CS  = w_out.ram_cs;
    assign PHASE   = r_state;
    assign HALTED  = RST && (r_state == ST_HALT);

endmodule

// File: tb/tb_seqcon_p.sv
// tb_seqcon_p: directed bench for seqcon_p. dut0 (MEM_WAIT=0) is driven from
// a per-cycle vector table; dut2 (MEM_WAIT=2) runs a hand-written LDA memory
// access with RDY held low. Strobe vectors use the bit order
// {IR,A,B,PDR,PORT_EN,PORT_RD,PC_EN,PC_LOAD,ALU_EN,ALU_OE,RAM_OE,RDR,RAM_CS}.
module tb_seqcon_p;

    localparam logic [12:0] M_CS  = 13'h0001;
    localparam logic [12:0] M_RDR = 13'h0002;
    localparam logic [12:0] M_ROE = 13'h0004;
    localparam logic [12:0] M_AOE = 13'h0008;
    localparam logic [12:0] M_ALU = 13'h0010;
    localparam logic [12:0] M_PCL = 13'h0020;
    localparam logic [12:0] M_PCE = 13'h0040;
    localparam logic [12:0] M_PRD = 13'h0080;
    localparam logic [12:0] M_PEN = 13'h0100;
    localparam logic [12:0] M_PDR = 13'h0200;
    localparam logic [12:0] M_BEN = 13'h0400;
    localparam logic [12:0] M_AEN = 13'h0800;
    localparam logic [12:0] M_IR  = 13'h1000;
    localparam logic [12:0] F     = M_CS | M_ROE;
    localparam logic [12:0] FW    = M_CS | M_ROE | M_IR | M_RDR;

    logic       CLK = 1'b0;
    logic       RST, HOLD, STEP, START, RDY, I, CF, OF, SF, ZF;
    logic [3:0] OPCODE;
    logic [6:0] ADDR;
    logic [12:0] s0, s2;
    logic [2:0]  ph0, ph2;
    logic        h0, h2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    seqcon_p #(.OPW(4), .AW(7), .MEM_WAIT(0), .STEP_EN(1)) dut0 (
        .CLK(CLK), .RST(RST), .HOLD(HOLD), .STEP(STEP), .START(START), .RDY(RDY),
        .OPCODE(OPCODE), .ADDR(ADDR), .CF(CF), .OF(OF), .SF(SF), .ZF(ZF), .I(I),
        .IR_EN(s0[12]), .A_EN(s0[11]), .B_EN(s0[10]), .PDR_EN(s0[9]),
        .PORT_EN(s0[8]), .PORT_RD(s0[7]), .PC_EN(s0[6]), .PC_LOAD(s0[5]),
        .ALU_EN(s0[4]), .ALU_OE(s0[3]), .RAM_OE(s0[2]), .RDR_EN(s0[1]),
        .RAM_CS(s0[0]), .PHASE(ph0), .HALTED(h0)
    );

    seqcon_p #(.OPW(4), .AW(7), .MEM_WAIT(2), .STEP_EN(1)) dut2 (
        .CLK(CLK), .RST(RST), .HOLD(HOLD), .STEP(STEP), .START(START), .RDY(RDY),
        .OPCODE(OPCODE), .ADDR(ADDR), .CF(CF), .OF(OF), .SF(SF), .ZF(ZF), .I(I),
        .IR_EN(s2[12]), .A_EN(s2[11]), .B_EN(s2[10]), .PDR_EN(s2[9]),
        .PORT_EN(s2[8]), .PORT_RD(s2[7]), .PC_EN(s2[6]), .PC_LOAD(s2[5]),
        .ALU_EN(s2[4]), .ALU_OE(s2[3]), .RAM_OE(s2[2]), .RDR_EN(s2[1]),
        .RAM_CS(s2[0]), .PHASE(ph2), .HALTED(h2)
    );

    typedef struct {
        logic        rst, hold, step, start, rdy;
        logic [3:0]  op;
        logic        i, zf;
        logic [2:0]  ph;
        logic [12:0] st;
        logic        hl;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic rst, hold, step, start, rdy,
                                input logic [3:0] op, input logic i, zf,
                                input logic [2:0] ph, input logic [12:0] st,
                                input logic hl);
        vec_t v;
        v = '{rst, hold, step, start, rdy, op, i, zf, ph, st, hl};
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    initial begin
        int n_fw, n_mw, n_hit, hit_at;
        bit reached;
        logic [12:0] exp_st;

        RST = 1'b0; HOLD = 1'b0; STEP = 1'b0; START = 1'b0; RDY = 1'b1;
        OPCODE = 4'd0; ADDR = 7'h2a; I = 1'b0;
        CF = 1'b0; OF = 1'b0; SF = 1'b0; ZF = 1'b0;

        //   rst hold stp sta rdy  op  i  zf  ph  strobes        halted
        // ALU instruction: five cycles
        add(1, 0, 0, 0, 1,  3, 0, 0,  0, F,             0);
        add(1, 0, 0, 0, 1,  3, 0, 0,  1, FW,            0);
        add(1, 0, 0, 0, 1,  3, 0, 0,  2, M_PCE,         0);
        add(1, 0, 0, 0, 1,  3, 0, 0,  3, M_ALU,         0);
        add(1, 0, 0, 0, 1,  3, 0, 0,  5, M_AOE | M_AEN, 0);
        // ALU instruction aborted by reset asserted in EXEC
        add(1, 0, 0, 0, 1,  3, 0, 0,  0, F,             0);
        add(1, 0, 0, 0, 1,  3, 0, 0,  1, FW,            0);
        add(1, 0, 0, 0, 1,  3, 0, 0,  2, M_PCE,         0);
        add(0, 0, 0, 0, 1,  3, 0, 0,  3, 13'h0,         0);
        add(0, 0, 0, 0, 1,  3, 0, 0,  0, 13'h0,         0);
        // JZ with ZF=1 at DECODE, ZF dropped during EXEC: taken
        add(1, 0, 0, 0, 1,  5, 0, 1,  0, F,             0);
        add(1, 0, 0, 0, 1,  5, 0, 1,  1, FW,            0);
        add(1, 0, 0, 0, 1,  5, 0, 1,  2, M_PCE,         0);
        add(1, 0, 0, 0, 1,  5, 0, 0,  3, M_PCL,         0);
        add(1, 0, 0, 0, 1,  5, 0, 0,  5, 13'h0,         0);
        // JZ with ZF=0 at DECODE, ZF raised during EXEC: not taken
        add(1, 0, 0, 0, 1,  5, 0, 0,  0, F,             0);
        add(1, 0, 0, 0, 1,  5, 0, 0,  1, FW,            0);
        add(1, 0, 0, 0, 1,  5, 0, 0,  2, M_PCE,         0);
        add(1, 0, 0, 0, 1,  5, 0, 1,  3, 13'h0,         0);
        add(1, 0, 0, 0, 1,  5, 0, 1,  5, 13'h0,         0);
        // HLT, then STEP runs one OUT and halts again
        add(1, 0, 0, 0, 1,  0, 0, 0,  0, F,             0);
        add(1, 0, 0, 0, 1,  0, 0, 0,  1, FW,            0);
        add(1, 0, 0, 0, 1,  0, 0, 0,  2, M_PCE,         0);
        add(1, 0, 0, 0, 1,  0, 0, 0,  6, 13'h0,         1);
        add(1, 0, 0, 0, 1, 10, 0, 0,  6, 13'h0,         1);
        add(1, 0, 1, 0, 1, 10, 0, 0,  6, 13'h0,         1);
        add(1, 0, 0, 0, 1, 10, 0, 0,  0, F,             0);
        add(1, 0, 0, 0, 1, 10, 0, 0,  1, FW,            0);
        add(1, 0, 0, 0, 1, 10, 0, 0,  2, M_PCE,         0);
        add(1, 0, 0, 0, 1, 10, 0, 0,  3, M_PEN,         0);
        add(1, 0, 0, 0, 1, 10, 0, 0,  5, 13'h0,         0);
        add(1, 0, 0, 0, 1, 10, 0, 0,  6, 13'h0,         1);
        // START resumes free run with an IN instruction
        add(1, 0, 0, 1, 1,  9, 0, 0,  6, 13'h0,         1);
        add(1, 0, 0, 0, 1,  9, 0, 0,  0, F,             0);
        add(1, 0, 0, 0, 1,  9, 0, 0,  1, FW,            0);
        add(1, 0, 0, 0, 1,  9, 0, 0,  2, M_PCE,         0);
        add(1, 0, 0, 0, 1,  9, 0, 0,  3, M_PRD | M_PDR, 0);
        add(1, 0, 0, 0, 1,  9, 0, 0,  5, 13'h0,         0);
        // RDY low in FWAIT, then HOLD for 4 cycles with RDY high
        add(1, 0, 0, 0, 1,  9, 0, 0,  0, F,             0);
        add(1, 0, 0, 0, 0,  9, 0, 0,  1, F,             0);
        add(1, 1, 0, 0, 1,  9, 0, 0,  1, FW,            0);
        add(1, 1, 0, 0, 1,  9, 0, 0,  1, FW,            0);
        add(1, 1, 0, 0, 1,  9, 0, 0,  1, FW,            0);
        add(1, 1, 0, 0, 1,  9, 0, 0,  1, FW,            0);
        add(1, 0, 0, 0, 1,  9, 0, 0,  1, FW,            0);
        add(1, 0, 0, 0, 1,  9, 0, 0,  2, M_PCE,         0);
        add(1, 0, 0, 0, 1,  9, 0, 0,  3, M_PRD | M_PDR, 0);
        add(1, 0, 0, 0, 1,  9, 0, 0,  5, 13'h0,         0);
        // LDB immediate
        add(1, 0, 0, 0, 1, 11, 1, 0,  0, F,             0);
        add(1, 0, 0, 0, 1, 11, 1, 0,  1, FW,            0);
        add(1, 0, 0, 0, 1, 11, 1, 0,  2, M_PCE,         0);
        add(1, 0, 0, 0, 1, 11, 1, 0,  3, M_BEN,         0);
        add(1, 0, 0, 0, 1, 11, 1, 0,  5, 13'h0,         0);
        // HLT, then START and STEP together: free run, no re-halt after WB
        add(1, 0, 0, 0, 1,  0, 0, 0,  0, F,             0);
        add(1, 0, 0, 0, 1,  0, 0, 0,  1, FW,            0);
        add(1, 0, 0, 0, 1,  0, 0, 0,  2, M_PCE,         0);
        add(1, 0, 1, 1, 1,  3, 0, 0,  6, 13'h0,         1);
        add(1, 0, 0, 0, 1,  3, 0, 0,  0, F,             0);
        add(1, 0, 0, 0, 1,  3, 0, 0,  1, FW,            0);
        add(1, 0, 0, 0, 1,  3, 0, 0,  2, M_PCE,         0);
        add(1, 0, 0, 0, 1,  3, 0, 0,  3, M_ALU,         0);
        add(1, 0, 0, 0, 1,  3, 0, 0,  5, M_AOE | M_AEN, 0);
        // Undefined opcode 12 behaves as NOP
        add(1, 0, 0, 0, 1, 12, 0, 0,  0, F,             0);
        add(1, 0, 0, 0, 1, 12, 0, 0,  1, FW,            0);
        add(1, 0, 0, 0, 1, 12, 0, 0,  2, M_PCE,         0);
        add(1, 0, 0, 0, 1, 12, 0, 0,  3, 13'h0,         0);
        add(1, 0, 0, 0, 1, 12, 0, 0,  5, 13'h0,         0);
        add(1, 0, 0, 0, 1, 12, 0, 0,  0, F,             0);

        // Initial reset
        @(posedge CLK);
        @(posedge CLK);
        #1;

        for (int k = 0; k < tbl.size(); k++) begin
            RST    = tbl[k].rst;
            HOLD   = tbl[k].hold;
            STEP   = tbl[k].step;
            START  = tbl[k].start;
            RDY    = tbl[k].rdy;
            OPCODE = tbl[k].op;
            I      = tbl[k].i;
            ZF     = tbl[k].zf;
            @(negedge CLK);
            $display("row %0d: phase=%0d strobes=%h halted=%b", k, ph0, s0, h0);
            check($sformatf("row%0d {phase,strobes,halted}", k),
                  {15'h0, ph0, s0, h0}, {15'h0, tbl[k].ph, tbl[k].st, tbl[k].hl});
            @(posedge CLK);
            #1;
        end

        // dut2: LDA direct, MEM_WAIT=2, RDY low for the first 5 MWAIT cycles
        RST = 1'b0; HOLD = 1'b0; STEP = 1'b0; START = 1'b0; RDY = 1'b1;
        OPCODE = 4'd1; I = 1'b0; ZF = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        n_fw = 0; n_mw = 0; n_hit = 0; hit_at = 0; reached = 1'b0;
        for (int c = 0; c < 40 && !reached; c++) begin
            RDY = (ph2 == 3'd4 && n_mw < 5) ? 1'b0 : 1'b1;
            @(negedge CLK);
            $display("lda cycle %0d: phase=%0d strobes=%h rdy=%b", c, ph2, s2, RDY);
            if (ph2 == 3'd1) begin
                n_fw++;
                exp_st = (n_fw == 3) ? FW : F;
                check($sformatf("lda fwait%0d strobes", n_fw), {19'h0, s2}, {19'h0, exp_st});
            end
            if (ph2 == 3'd4) begin
                n_mw++;
                exp_st = (n_mw == 6) ? (F | M_RDR | M_AEN) : F;
                check($sformatf("lda mwait%0d strobes", n_mw), {19'h0, s2}, {19'h0, exp_st});
            end
            if ((s2 & (M_RDR | M_AEN)) == (M_RDR | M_AEN)) begin
                n_hit++;
                hit_at = n_mw;
            end
            if (ph2 == 3'd5) begin
                reached = 1'b1;
                check("lda wb strobes", {19'h0, s2}, 32'h0);
            end
            @(posedge CLK);
            #1;
        end
        check("lda reached WB", {31'h0, reached}, 32'h1);
        check("lda fwait cycles", n_fw, 32'd3);
        check("lda mwait cycles", n_mw, 32'd6);
        check("lda rdr+a_en pulses", n_hit, 32'd1);
        check("lda rdr+a_en at mwait cycle", hit_at, 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
